dmem_ctrl: RTL and testbench

- Parametrised data-memory controller that replaces the single-cycle data memory behind the pipeline's MEM stage.
- Adds byte, halfword and word accesses with sign or zero extension on loads.
- Adds a configurable number of wait states, reported to the pipeline through a stall handshake.
- Adds misaligned-access detection. Word storage is internal; the pipeline core drives the request side.

---
 rtl/dmem_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory, byte/half/word access, wait states.
// Optional misaligned-access trap enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t state, stateNext;
   logic [3:0] waitCnt, waitCntNext;

   logic             latWe;
   logic [1:0]       latSize;
   logic             latUns;
   logic [IDX_W+1:0] latAddr;
   logic [31:0]      latWdata;

   logic [31:0] rdataQ;
   logic [31:0] mem [DEPTH_WORDS];

   logic             curWe;
   logic             curUns;
   logic [1:0]       curSize;
   logic [IDX_W+1:0] curAddr;
   logic [IDX_W+1:0] alignAddr;
   logic [31:0]      curWdata;
   logic [IDX_W-1:0] curIdx;
   logic [1:0]       curLane;

   logic        isIdle;
   logic        accept;
   logic        doAccess;
   logic        trapMis;
   logic [31:0] rdWord;
   logic [31:0] shWord;
   logic [31:0] loadVal;
   logic [31:0] wrData;
   logic [3:0]  wrBe;

   // Upper address bits only alias; they never select storage.
   logic unusedAddr;
   assign unusedAddr = ^req_addr[31:IDX_W+2];

   assign isIdle = (state == IDLE);
   assign accept = isIdle & req_valid & rst_n;

   // Live request fields in IDLE, latched copy while BUSY.
   always_comb begin
      curWe    = latWe;
      curSize  = latSize;
      curUns   = latUns;
      curAddr  = latAddr;
      curWdata = latWdata;
      if (isIdle) begin
         curWe    = req_we;
         curSize  = req_size;
         curUns   = req_unsigned;
         curAddr  = req_addr[IDX_W+1:0];
         curWdata = req_wdata;
      end
   end

   // Force natural alignment by clearing low address bits.
   always_comb begin
      alignAddr = curAddr;
      unique case (1'b1)
         (curSize == 2'b00): alignAddr = curAddr;
         (curSize == 2'b01): alignAddr[0] = 1'b0;
         default:            alignAddr[1:0] = 2'b00;
      endcase
   end

   assign curIdx  = alignAddr[IDX_W+1:2];
   assign curLane = alignAddr[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
   logic errQ;
   logic isMis;

   assign isMis = (curSize == 2'b01) ? curAddr[0] :
                  ((curSize != 2'b00) & (curAddr[1:0] != 2'b00));
   assign trapMis = isMis;
   assign misalign_err = (state == DONE) & errQ;

   // Remember whether the accepted request trapped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errQ <= 1'b0;
      end else if (accept) begin
         errQ <= isMis;
      end
   end
`else
   assign trapMis = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Next state, wait countdown, stall and access strobe.
   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      doAccess    = 1'b0;
      stall       = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && rst_n) begin
               stall = 1'b1;
               if (trapMis) begin
                  stateNext = DONE;
               end else if (WS == 4'd0) begin
                  stateNext = DONE;
                  doAccess  = 1'b1;
               end else begin
                  stateNext   = BUSY;
                  waitCntNext = WS;
               end
            end
         end
         BUSY: begin
            stall       = 1'b1;
            waitCntNext = waitCnt - 4'd1;
            if (waitCnt == 4'd1) begin
               doAccess  = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State register, countdown and request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         waitCnt  <= 4'd0;
         latWe    <= 1'b0;
         latSize  <= 2'b00;
         latUns   <= 1'b0;
         latAddr  <= '0;
         latWdata <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         if (accept) begin
            latWe    <= req_we;
            latSize  <= req_size;
            latUns   <= req_unsigned;
            latAddr  <= req_addr[IDX_W+1:0];
            latWdata <= req_wdata;
         end
      end
   end

   // Store lane enables and data replicated across lanes.
   always_comb begin
      wrBe   = 4'b1111;
      wrData = curWdata;
      unique case (1'b1)
         (curSize == 2'b00): begin
            wrBe   = 4'b0001 << curLane;
            wrData = {4{curWdata[7:0]}};
         end
         (curSize == 2'b01): begin
            wrBe   = curLane[1] ? 4'b1100 : 4'b0011;
            wrData = {2{curWdata[15:0]}};
         end
         default: begin
            wrBe   = 4'b1111;
            wrData = curWdata;
         end
      endcase
   end

   assign rdWord = mem[curIdx];
   assign shWord = rdWord >> {curLane, 3'b000};

   // Select the addressed byte/half and extend it.
   always_comb begin
      loadVal = rdWord;
      unique case (1'b1)
         (curSize == 2'b00): begin
            loadVal = curUns ? {24'd0, shWord[7:0]} :
                               {{24{shWord[7]}}, shWord[7:0]};
         end
         (curSize == 2'b01): begin
            loadVal = curUns ? {16'd0, shWord[15:0]} :
                               {{16{shWord[15]}}, shWord[15:0]};
         end
         default: begin
            loadVal = rdWord;
         end
      endcase
   end

   // Byte-lane write into the word array.
   always_ff @(posedge clk) begin
      if (doAccess && curWe) begin
         for (int b = 0; b < 4; b++) begin
            if (wrBe[b]) begin
               mem[curIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
         end
      end
   end

   // Load result register, held until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdataQ <= '0;
      end else if (doAccess && !curWe) begin
         rdataQ <= loadVal;
`ifdef DMEM_MISALIGN_TRAP_EN
      end else if (accept && trapMis) begin
         rdataQ <= '0;
`endif
      end
   end

   assign rsp_valid = (state == DONE);
   assign rsp_rdata = rdataQ;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl
// against a behavioural memory model.
module tb_dmem_ctrl;

   localparam int WS    = 2;
   localparam int DEPTH = 256;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign_err;

   int tests;
   int fails;
   bit chkEn;

   logic        expStall;
   logic        expRsp;
   logic        expErr;
   logic [31:0] expRdata;

   int stallRun;
   int lastStallRun;

   logic [31:0] mdl [DEPTH];

   dmem_ctrl #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .stall(stall),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .misalign_err(misalign_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model expectations.
   always @(negedge clk) begin
      if (chkEn) begin
         chk("stall", {31'd0, stall}, {31'd0, expStall});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, expRsp});
         chk("misalign_err", {31'd0, misalign_err}, {31'd0, expErr});
         chk("rsp_rdata", rsp_rdata, expRdata);
         if (stall) stallRun++;
         if (rsp_valid) begin
            lastStallRun = stallRun;
            stallRun = 0;
         end
      end
   end

   function automatic logic [31:0] alignOf(input logic [1:0] sz,
                                           input logic [31:0] a);
      logic [31:0] r;
      r = a;
      if (sz == 2'b01) r[0] = 1'b0;
      else if (sz != 2'b00) r[1:0] = 2'b00;
      return r;
   endfunction

   function automatic logic [31:0] mdlLoad(input logic [1:0] sz,
                                           input logic uns,
                                           input logic [31:0] ea);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      int sh;
      w  = mdl[ea[9:2]];
      sh = 8 * int'(ea[1:0]);
      b  = w[sh +: 8];
      h  = w[sh +: 16];
      if (sz == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
      if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
      return w;
   endfunction

   task automatic mdlStore(input logic [1:0] sz, input logic [31:0] ea,
                           input logic [31:0] wd);
      int sh;
      sh = 8 * int'(ea[1:0]);
      if (sz == 2'b00) mdl[ea[9:2]][sh +: 8] = wd[7:0];
      else if (sz == 2'b01) mdl[ea[9:2]][sh +: 16] = wd[15:0];
      else mdl[ea[9:2]] = wd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         expStall  = 1'b0;
         expRsp    = 1'b0;
         expErr    = 1'b0;
      end
   endtask

   // Issue one request; returns 1 time unit into its response cycle.
   task automatic doReq(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
      logic [31:0] ea;
      bit trapped;
      ea = alignOf(sz, a);
      trapped = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      trapped = (ea != a);
`endif
      @(posedge clk);
      #1;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      expStall     = 1'b1;
      expRsp       = 1'b0;
      expErr       = 1'b0;
      if (trapped) begin
         @(posedge clk);
         #1;
         expErr   = 1'b1;
         expRdata = 32'd0;
      end else begin
         for (int i = 0; i < WS; i++) begin
            @(posedge clk);
            #1;
         end
         @(posedge clk);
         #1;
         if (we) mdlStore(sz, ea, wd);
         else expRdata = mdlLoad(sz, uns, ea);
      end
      expStall = 1'b0;
      expRsp   = 1'b1;
   endtask

   task automatic resetNow(input int n);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      expStall  = 1'b0;
      expRsp    = 1'b0;
      expErr    = 1'b0;
      expRdata  = 32'd0;
      stallRun  = 0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, misalign_err}, 32'd0);
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      tests        = 0;
      fails        = 0;
      chkEn        = 1'b0;
      stallRun     = 0;
      lastStallRun = 0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      expStall     = 1'b0;
      expRsp       = 1'b0;
      expErr       = 1'b0;
      expRdata     = 32'd0;

      @(posedge clk);
      #1;
      chkEn = 1'b1;
      resetNow(2);

      for (int i = 0; i < 16; i++) begin
         doReq(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
      end
      idle(2);

      doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      #1;
      chk("stall_len", 32'(lastStallRun), 32'd3);
      doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      chk("ld_w10", rsp_rdata, 32'hDEADBEEF);

      doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
      doReq(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
      doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      chk("ld_w10b", rsp_rdata, 32'h80223344);
      doReq(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
      chk("ld_b13s", rsp_rdata, 32'hFFFFFF80);
      doReq(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
      chk("ld_b13u", rsp_rdata, 32'h00000080);

      doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788);
      doReq(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD);
      doReq(1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
      chk("ld_h22s", rsp_rdata, 32'hFFFFABCD);
      doReq(1'b0, 2'b01, 1'b1, 32'h20, 32'd0);
      chk("ld_h20u", rsp_rdata, 32'h00007788);

      doReq(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D);
      doReq(1'b0, 2'b10, 1'b0, 32'h06, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("mis_rdata", rsp_rdata, 32'd0);
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
`else
      chk("mis_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("mis_err", {31'd0, misalign_err}, 32'd0);
`endif
      doReq(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
      chk("ld_w04", rsp_rdata, 32'hCAFEF00D);

      doReq(1'b1, 2'b10, 1'b0, 32'h400, 32'h0BADC0DE);
      doReq(1'b0, 2'b10, 1'b0, 32'h000, 32'd0);
      chk("alias", rsp_rdata, 32'h0BADC0DE);

      doReq(1'b1, 2'b10, 1'b0, 32'h30, 32'h01234567);
      @(posedge clk);
      #1;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h30;
      req_wdata    = 32'h76543210;
      expStall     = 1'b1;
      expRsp       = 1'b0;
      @(posedge clk);
      #1;
      resetNow(2);
      doReq(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
      chk("rst_busy", rsp_rdata, 32'h01234567);

      doReq(1'b1, 2'b10, 1'b0, 32'h30, 32'h99999999);
      resetNow(1);
      doReq(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
      chk("rst_done", rsp_rdata, 32'h99999999);

      for (int n = 0; n < 300; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = ($urandom & 32'hFFFF_FC00) |
              32'($urandom_range(0, 15) * 4) |
              32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         doReq(1'($urandom), sz, 1'($urandom), a, $urandom);
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
